mmio_master: RTL and testbench

- Bus initiator that turns single core load/store requests into transactions on the peripheral register bus.
- Peripheral bus signals: wready/waddr/wdata/wstrb, wvalid; rready/raddr, rvalid, rresp/rdata.
- Sits between the core's data-memory port and MMIO slaves (timer, UART, etc.).
- Handles byte-lane steering, load sign/zero extension, misalignment detection and a per-transaction timeout.

---
 rtl/mmio_master.sv | 200 ++++++++++++++++++++
 tb/tb_mmio_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master.sv
// Single-outstanding MMIO bus initiator: turns core load/store requests into
// peripheral register-bus transactions with lane steering, extension and timeout.
module mmio_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wready,
    input  logic        wvalid,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        rready,
    input  logic        rvalid,
    output logic [31:0] raddr,
    input  logic        rresp,
    input  logic [31:0] rdata
);

    // Handshakes: a core request is taken on an edge where req_valid && req_ready;
    // a bus strobe (wready/rready) holds until the slave's wvalid/rvalid is sampled
    // high at an edge; rresp is only looked at while waiting for read data.

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [1:0]      a_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [CW-1:0]   cnt;

    logic            misaligned;
    logic            timeout_hit;
    logic [31:0]     st_data;
    logic [3:0]      st_strb;

    assign misaligned = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // cnt counts completed cycles in the current waiting state.
    assign timeout_hit = (TIMEOUT > 0) && (int'(cnt) == TIMEOUT - 1);

    always_comb begin
        st_data = req_wdata;
        st_strb = 4'b1111;
        case (req_size)
            2'd0: begin
                st_data = {4{req_wdata[7:0]}};
                st_strb = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                st_data = {2{req_wdata[15:0]}};
                st_strb = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_data = req_wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] a,
                                                input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[8*a +: 8];
        h = d[16*a[1] +: 16];
        case (sz)
            2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            wready     <= 1'b0;
            waddr      <= 32'b0;
            wdata      <= 32'b0;
            wstrb      <= 4'b0;
            rready     <= 1'b0;
            raddr      <= 32'b0;
            a_q        <= 2'b0;
            size_q     <= 2'b0;
            uns_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        a_q       <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        cnt       <= '0;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'b0;
                        end else if (req_we) begin
                            state  <= WR;
                            wready <= 1'b1;
                            waddr  <= {req_addr[31:2], 2'b00};
                            wdata  <= st_data;
                            wstrb  <= st_strb;
                        end else begin
                            state  <= RD_REQ;
                            rready <= 1'b1;
                            raddr  <= {req_addr[31:2], 2'b00};
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (wvalid || timeout_hit) begin
                        state      <= RESP;
                        wready     <= 1'b0;
                        wstrb      <= 4'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= !wvalid;
                        resp_rdata <= 32'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD_REQ: begin
                    if (rvalid) begin
                        state  <= RD_WAIT;
                        rready <= 1'b0;
                        cnt    <= '0;
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD_WAIT: begin
                    // Returning data takes priority over a timeout on the same edge.
                    if (rresp) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extend(rdata, a_q, size_q, uns_q);
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: table of load/store/error/timeout vectors
// against a configurable slave, plus a mid-transaction reset sequence.
module tb_mmio_master;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic [1:0]  req_size = 2'b0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wready;
    logic        wvalid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rready;
    logic        rvalid;
    logic [31:0] raddr;
    logic        rresp;
    logic [31:0] rdata;

    logic        wvalid_en = 1'b1;
    logic        rvalid_en = 1'b1;
    logic        rresp_en  = 1'b1;
    int          rresp_lat = 1;
    logic [31:0] rdata_drv = 32'b0;
    int          rcnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mmio_master #(.TIMEOUT(16)) dut (
        .clk(clk), .resetb(resetb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wready(wready), .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .rready(rready), .rvalid(rvalid), .raddr(raddr), .rresp(rresp), .rdata(rdata)
    );

    // Slave model: rresp pulses rresp_lat cycles after the read-request handshake edge.
    assign wvalid = wvalid_en;
    assign rvalid = rvalid_en;
    assign rdata  = rdata_drv;
    assign rresp  = rresp_en && (rcnt == rresp_lat);

    always @(posedge clk or negedge resetb) begin
        if (!resetb) rcnt <= 0;
        else if (rready && rvalid) rcnt <= 1;
        else if (rcnt > 0 && rcnt < 1000) rcnt <= rcnt + 1;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rd;
        logic        wv;
        logic        rr_en;
        int          rr_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_wcyc;
        int          exp_rcyc;
        int          exp_lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [1:0] size, input logic uns, input logic [31:0] rd,
                                input logic wv, input logic rr_en, input int rr_lat,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_wstrb, input int exp_wcyc,
                                input int exp_rcyc, input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.size = size; v.uns = uns; v.rd = rd;
        v.wv = wv; v.rr_en = rr_en; v.rr_lat = rr_lat;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_addr = exp_addr;
        v.exp_wdata = exp_wdata; v.exp_wstrb = exp_wstrb;
        v.exp_wcyc = exp_wcyc; v.exp_rcyc = exp_rcyc; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctl"}, {27'b0, req_ready, resp_valid, resp_err, wready, rready}, 32'b0);
        check({nm, " strb"}, {28'b0, wstrb}, 32'b0);
        check({nm, " rdata"}, resp_rdata, 32'b0);
        check({nm, " waddr"}, waddr, 32'b0);
        check({nm, " wdata"}, wdata, 32'b0);
        check({nm, " raddr"}, raddr, 32'b0);
    endtask

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int n, lat, wc, rc;
        logic got;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_strb;
        wvalid_en = v.wv;
        rvalid_en = 1'b1;
        rresp_en  = v.rr_en;
        rresp_lat = v.rr_lat;
        rdata_drv = v.rd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
        req_we = v.we; req_addr = v.addr; req_wdata = v.wd;
        req_size = v.size; req_unsigned = v.uns; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wc = 0; rc = 0; got = 1'b0;
        s_addr = 32'b0; s_wdata = 32'b0; s_strb = 4'b0;
        while (1) begin
            @(negedge clk);
            if (wready) begin
                if (wc == 0) begin s_addr = waddr; s_wdata = wdata; s_strb = wstrb; end
                wc++;
            end
            if (rready) begin
                if (rc == 0) s_addr = raddr;
                rc++;
            end
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (lat >= 40) break;
            @(posedge clk);
            lat++;
        end
        check($sformatf("v%0d resp_seen", idx), {31'b0, got}, 32'd1);
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d resp_err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
        check($sformatf("v%0d wready_cycles", idx), wc, v.exp_wcyc);
        check($sformatf("v%0d rready_cycles", idx), rc, v.exp_rcyc);
        if (v.exp_wcyc > 0) begin
            check($sformatf("v%0d waddr", idx), s_addr, v.exp_addr);
            check($sformatf("v%0d wdata", idx), s_wdata, v.exp_wdata);
            check($sformatf("v%0d wstrb", idx), {28'b0, s_strb}, {28'b0, v.exp_wstrb});
        end
        if (v.exp_rcyc > 0) check($sformatf("v%0d raddr", idx), s_addr, v.exp_addr);
        @(negedge clk);
        check($sformatf("v%0d resp_pulse_end", idx), {31'b0, resp_valid}, 32'd0);
        check($sformatf("v%0d rdata_clear", idx), resp_rdata, 32'b0);
    endtask

    initial begin
        int n;
        vecs[0]  = mk(1, 32'h8000_0008, 32'h1234_5678, 2, 0, 0, 1, 1, 1,
                      32'h0, 0, 32'h8000_0008, 32'h1234_5678, 4'hF, 1, 0, 1);
        vecs[1]  = mk(1, 32'h8000_0003, 32'hDEAD_BEA5, 0, 0, 0, 1, 1, 1,
                      32'h0, 0, 32'h8000_0000, 32'hA5A5_A5A5, 4'b1000, 1, 0, 1);
        vecs[2]  = mk(1, 32'h8000_0002, 32'h1234_BEEF, 1, 0, 0, 1, 1, 1,
                      32'h0, 0, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 1, 0, 1);
        vecs[3]  = mk(1, 32'h8000_0004, 32'h0000_003C, 0, 0, 0, 1, 1, 1,
                      32'h0, 0, 32'h8000_0004, 32'h3C3C_3C3C, 4'b0001, 1, 0, 1);
        vecs[4]  = mk(0, 32'h4000_0011, 0, 0, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'h0000_007F, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[5]  = mk(0, 32'h4000_0012, 0, 0, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'hFFFF_FFFF, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[6]  = mk(0, 32'h4000_0013, 0, 0, 1, 32'h80FF_7F01, 1, 1, 1,
                      32'h0000_0080, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[7]  = mk(0, 32'h4000_0012, 0, 1, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'hFFFF_80FF, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[8]  = mk(0, 32'h4000_0010, 0, 2, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'h80FF_7F01, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[9]  = mk(0, 32'h4000_0012, 0, 1, 1, 32'h80FF_7F01, 1, 1, 1,
                      32'h0000_80FF, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[10] = mk(0, 32'h4000_0010, 0, 1, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'h0000_7F01, 0, 32'h4000_0010, 0, 0, 0, 1, 2);
        vecs[11] = mk(0, 32'h4000_0010, 0, 0, 1, 32'h80FF_7F01, 1, 1, 3,
                      32'h0000_0001, 0, 32'h4000_0010, 0, 0, 0, 1, 4);
        vecs[12] = mk(0, 32'h4000_0002, 0, 2, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'h0, 1, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 32'h8000_0001, 32'h0000_BEEF, 1, 0, 0, 1, 1, 1,
                      32'h0, 1, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 32'h4000_0000, 0, 3, 0, 32'h80FF_7F01, 1, 1, 1,
                      32'h0, 1, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 32'h8000_0010, 32'hCAFE_F00D, 2, 0, 0, 0, 1, 1,
                      32'h0, 1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 16, 0, 16);
        vecs[16] = mk(0, 32'h4000_0014, 0, 2, 0, 32'h80FF_7F01, 1, 0, 1,
                      32'h0, 1, 32'h4000_0014, 0, 0, 0, 1, 17);
        vecs[17] = mk(0, 32'h4000_0014, 0, 2, 0, 32'h80FF_7F01, 1, 1, 16,
                      32'h80FF_7F01, 0, 32'h4000_0014, 0, 0, 0, 1, 17);

        // Reset state
        #1 check_all_zero("reset");
        #20;
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while waiting for read data: outputs drop at once, no response follows.
        rresp_en = 1'b0; rvalid_en = 1'b1; wvalid_en = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_we = 1'b0; req_addr = 32'h4000_0020; req_size = 2'd2;
        req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetb = 1'b0;
        #1 check_all_zero("midreset");
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        check("midreset_no_resp", n, 0);
        resetb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ready", {31'b0, req_ready}, 32'd1);
        run_vec(vecs[8], 100);
        run_vec(vecs[0], 101);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
